// File: rtl/mosi_cmd_sequencer.sv
// Multi-bank MOSI command store with host readback and a playback sequencer for the SPI engine.
// Latency: host readback 1 cycle; first cmd_valid 2 cycles after seq_start; one word per 2 cycles.
// Backpressure: cmd_data/cmd_index are held while cmd_valid & ~cmd_ready; no word is dropped or skipped.
module mosi_cmd_sequencer #(
  parameter int NUM_BANKS = 16,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [BANK_W-1:0] seq_bank,
  input  logic [ADDR_W-1:0] seq_last,
  input  logic              seq_loop,
  input  logic              seq_start,
  input  logic              seq_stop,
  output logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] cmd_index,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              seq_busy,
  output logic              seq_done
);

  localparam int MEM_AW = BANK_W + ADDR_W;
  localparam logic [BANK_W:0] NB_EXT = (BANK_W + 1)'(NUM_BANKS);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

  // Sized to the full {bank, addr} space; banks >= NUM_BANKS are never written or read.
  logic [DATA_W-1:0] mem [0:(1 << MEM_AW) - 1];

  state_t            state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              loop_q, loop_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Zero-extend before comparing so non-power-of-two bank counts are handled.
  function automatic logic bank_ok(input logic [BANK_W-1:0] b);
    return ({1'b0, b} < NB_EXT);
  endfunction

  // Single write port; out-of-range banks are dropped. Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en && bank_ok(wr_bank)) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // Host read port: sampled before this edge's write lands, giving read-first behaviour.
  always_comb begin
    rd_data_d = '0;
    if (bank_ok(rd_bank)) begin
      rd_data_d = mem[{rd_bank, rd_addr}];
    end
  end

  // Sequencer next-state, latched run parameters and sequencer read port.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    last_d     = last_q;
    loop_d     = loop_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    done_d     = 1'b0;
    cmd_data_d = cmd_data_q;
    case (state_q)
      IDLE: begin
        if (seq_start && bank_ok(seq_bank)) begin
          bank_d  = seq_bank;
          last_d  = seq_last;
          loop_d  = seq_loop;
          idx_d   = '0;
          stop_d  = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        cmd_data_d = mem[{bank_q, idx_q}];
        state_d    = PRESENT;
      end
      PRESENT: begin
        if (cmd_ready) begin
          if (idx_q != last_q) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
          end else if (loop_q && !stop_q && !seq_stop) begin
            idx_d   = '0;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A stop only ends looping; the pass in flight always finishes.
    if (state_q != IDLE && seq_stop) begin
      stop_d = 1'b1;
      loop_d = 1'b0;
    end
  end

  // State and output registers; reset drops cmd_valid at once because it decodes state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bank_q     <= '0;
      last_q     <= '0;
      loop_q     <= 1'b0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      done_q     <= 1'b0;
      cmd_data_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      last_q     <= last_d;
      loop_q     <= loop_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      done_q     <= done_d;
      cmd_data_q <= cmd_data_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_index = idx_q;
  assign cmd_valid = (state_q == PRESENT);
  assign seq_busy  = (state_q != IDLE);
  assign seq_done  = done_q;

endmodule

// File: tb/tb_mosi_cmd_sequencer.sv
// Directed bench for mosi_cmd_sequencer: a word-level memory model plus an expected-index queue
// are checked on every negedge; handshake order, data, hold-under-stall, done pulses and
// readback are compared there, with literal expectations on the key timing points.
module tb_mosi_cmd_sequencer;

  localparam int NB = 16;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [3:0]    wr_bank;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [3:0]    seq_bank;
  logic [AW-1:0] seq_last;
  logic          seq_loop;
  logic          seq_start;
  logic          seq_stop;
  logic [DW-1:0] cmd_data;
  logic [AW-1:0] cmd_index;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          seq_busy;
  logic          seq_done;

  mosi_cmd_sequencer #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
    .seq_bank(seq_bank), .seq_last(seq_last), .seq_loop(seq_loop),
    .seq_start(seq_start), .seq_stop(seq_stop),
    .cmd_data(cmd_data), .cmd_index(cmd_index), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .seq_busy(seq_busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Word-level model of the store: what each location holds, and whether it was ever written.
  logic [DW-1:0] mm [0:NB-1][0:(1<<AW)-1];
  bit            kn [0:NB-1][0:(1<<AW)-1];
  logic [DW-1:0] exp_rd = '0;
  bit            exp_rd_kn = 1'b0;

  // Readback sees the contents before this edge's write.
  always @(posedge clk) begin
    if (reset) begin
      exp_rd    = '0;
      exp_rd_kn = 1'b1;
    end else begin
      exp_rd    = mm[rd_bank][rd_addr];
      exp_rd_kn = kn[rd_bank][rd_addr];
      if (wr_en) begin
        mm[wr_bank][wr_addr] = wr_data;
        kn[wr_bank][wr_addr] = 1'b1;
      end
    end
  end

  int            exp_idx_q[$];
  logic [3:0]    run_bank = 4'd2;
  int            hs_total = 0;
  int            done_total = 0;
  int            e_idx;
  logic [DW-1:0] seen [0:3];
  bit            prev_stall = 1'b0;
  bit            prev_done = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (exp_rd_kn) chk("rd_data", rd_data, exp_rd);
      if (prev_stall) begin
        chk("stall_valid", cmd_valid, 1);
        chk("stall_data", cmd_data, prev_data);
        chk("stall_index", cmd_index, prev_idx);
      end
      if (cmd_valid) chk("valid_implies_busy", seq_busy, 1);
      if (cmd_valid && cmd_ready) begin
        hs_total++;
        if (exp_idx_q.size() == 0) begin
          checks++;
          $display("FAIL extra_handshake: got index %0d, expected no handshake", cmd_index);
        end else begin
          e_idx = exp_idx_q.pop_front();
          chk("hs_index", cmd_index, e_idx);
          chk("hs_data", cmd_data, mm[run_bank][cmd_index]);
          if (cmd_index < 4) seen[cmd_index[1:0]] = cmd_data;
        end
      end
      if (seq_done) begin
        done_total++;
        chk("done_not_busy", seq_busy, 0);
      end
      if (prev_done) chk("done_one_cycle", seq_done, 0);
      prev_done  = seq_done;
      prev_stall = cmd_valid && !cmd_ready;
      prev_data  = cmd_data;
      prev_idx   = cmd_index;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] b, input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_bank = b; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_pass(input int last, input int npass);
    for (int p = 0; p < npass; p++)
      for (int i = 0; i <= last; i++) exp_idx_q.push_back(i);
  endtask

  task automatic start_run(input logic [3:0] b, input int last, input logic lp);
    seq_bank = b; seq_last = AW'(last); seq_loop = lp; seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!seq_done && n < 400) begin
      tick();
      n++;
    end
    if (!seq_done) begin
      checks++;
      $display("FAIL done_timeout: got no seq_done after %0d cycles, expected a pulse", n);
    end
  endtask

  task automatic wait_present(input int idx, input int hs_target);
    int n = 0;
    while (!(cmd_valid && cmd_index == AW'(idx) && hs_total == hs_target) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL present_timeout: got no presentation of index %0d, expected one", idx);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected the bench to end");
    $fatal(1);
  end

  int n;
  int base_done;
  int base_hs;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    rd_bank = '0; rd_addr = '0; seq_bank = '0; seq_last = '0; seq_loop = 1'b0;
    seq_start = 1'b0; seq_stop = 1'b0; cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data, 0);
    chk("reset_cmd_valid", cmd_valid, 0);
    chk("reset_cmd_data", cmd_data, 0);
    chk("reset_cmd_index", cmd_index, 0);
    chk("reset_busy", seq_busy, 0);
    chk("reset_done", seq_done, 0);
    reset = 1'b0;
    tick();

    // Store contents; with 16 banks every 4-bit bank is in range, so the dropped
    // out-of-range write cannot be expressed at this parameterisation.
    wr(4'd4, 5, 16'h5555);
    wr(4'd3, 5, 16'h1234);
    for (int i = 0; i < 4; i++) wr(4'd2, i, 16'hA000 + DW'(i));
    for (int i = 0; i < 3; i++) wr(4'd5, i, 16'hC000 + DW'(i));

    rd_bank = 4'd3; rd_addr = AW'(5);
    tick();
    chk("rd_b3a5", rd_data, 16'h1234);
    rd_bank = 4'd4;
    tick();
    chk("rd_b4a5_prior", rd_data, 16'h5555);
    rd_bank = 4'd3;
    wr(4'd3, 5, 16'hBEEF);
    chk("rd_read_first", rd_data, 16'h1234);
    tick();
    chk("rd_after_write", rd_data, 16'hBEEF);
    rd_bank = 4'd2; rd_addr = '0;

    // Single pass, then a one-word run started in the seq_done cycle.
    run_bank = 4'd2;
    base_done = done_total;
    push_pass(3, 1);
    start_run(4'd2, 3, 1'b0);
    chk("busy_after_start", seq_busy, 1);
    chk("valid_after_start", cmd_valid, 0);
    tick();
    chk("valid_2nd_edge", cmd_valid, 1);
    chk("first_data", cmd_data, 16'hA000);
    chk("first_index", cmd_index, 0);
    wait_done(n);
    chk("pass_edges", n + 1, 8);
    chk("busy_at_done", seq_busy, 0);
    push_pass(0, 1);
    start_run(4'd2, 0, 1'b0);
    wait_done(n);
    chk("last0_edges", n, 2);
    tick();
    chk("done_count_two_runs", done_total - base_done, 2);
    chk("queue_empty_single", exp_idx_q.size(), 0);

    // Backpressure on index 1 for 7 cycles.
    base_hs = hs_total;
    push_pass(3, 1);
    start_run(4'd2, 3, 1'b0);
    wait_present(1, base_hs + 1);
    cmd_ready = 1'b0;
    repeat (7) tick();
    chk("bp_held_valid", cmd_valid, 1);
    chk("bp_held_index", cmd_index, 1);
    chk("bp_held_data", cmd_data, 16'hA001);
    cmd_ready = 1'b1;
    wait_done(n);
    tick();
    chk("queue_empty_bp", exp_idx_q.size(), 0);

    // Loop with stop during the second pass; live inputs changed to show latching.
    run_bank = 4'd5;
    base_hs = hs_total;
    push_pass(2, 2);
    start_run(4'd5, 2, 1'b1);
    seq_bank = 4'd7; seq_last = AW'(9); seq_loop = 1'b0;
    wait_present(0, base_hs + 3);
    seq_stop = 1'b1;
    tick();
    seq_stop = 1'b0;
    wait_done(n);
    tick();
    chk("loop_handshakes", hs_total - base_hs, 6);
    chk("queue_empty_loop", exp_idx_q.size(), 0);

    // Live edit before FETCH of index 3, plus an ignored start while busy.
    run_bank = 4'd2;
    base_done = done_total;
    push_pass(3, 1);
    start_run(4'd2, 3, 1'b0);
    wr(4'd2, 3, 16'h7777);
    seq_bank = 4'd3; seq_last = AW'(1); seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    wait_done(n);
    tick();
    chk("live_edit_data", seen[3], 16'h7777);
    chk("busy_start_one_done", done_total - base_done, 1);
    chk("queue_empty_live", exp_idx_q.size(), 0);

    // Reset while presenting.
    push_pass(3, 1);
    start_run(4'd2, 3, 1'b0);
    tick();
    chk("pre_reset_valid", cmd_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("reset_async_valid", cmd_valid, 0);
    chk("reset_async_busy", seq_busy, 0);
    exp_idx_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_valid", cmd_valid, 0);
    chk("post_reset_busy", seq_busy, 0);
    chk("post_reset_index", cmd_index, 0);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mosi_cmd_sequencer.md
# mosi_cmd_sequencer

Parametrised multi-bank MOSI command store with a built-in playback sequencer, for the RHD2000 SPI interface path. The host writes command words into any of `NUM_BANKS` banks and can read them back. A start pulse makes the sequencer stream a bank's words `0..seq_last` to the SPI engine over a valid/ready handshake, either once or looping. Everything runs in a single clock domain.

## Interface
- `NUM_BANKS`, 16: number of command banks. Must be ≥1. `BANK_W = max(1, clog2(NUM_BANKS))`.
- `ADDR_W`, 10: words per bank = 2^ADDR_W.
- `DATA_W`, 16: command word width.
- `clk` in 1: the only clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `wr_en` in 1: host write strobe.
- `wr_bank` in BANK_W: bank to write.
- `wr_addr` in ADDR_W: word address to write.
- `wr_data` in DATA_W: word to write.
- `rd_bank` in BANK_W: host readback bank.
- `rd_addr` in ADDR_W: host readback word address.
- `rd_data` out DATA_W: host readback word, registered.
- `seq_bank` in BANK_W: bank to play.
- `seq_last` in ADDR_W: last index to play, inclusive.
- `seq_loop` in 1: 1 = repeat the pass until stopped.
- `seq_start` in 1: single-cycle start pulse.
- `seq_stop` in 1: single-cycle stop pulse.
- `cmd_data` out DATA_W: command word presented to the SPI engine.
- `cmd_index` out ADDR_W: index of the word on `cmd_data`.
- `cmd_valid` out 1: `cmd_data` / `cmd_index` are valid.
- `cmd_ready` in 1: SPI engine accepts the presented word.
- `seq_busy` out 1: sequencer is not IDLE.
- `seq_done` out 1: one-cycle pulse when playback ends.

## Operation
- **Storage:** `NUM_BANKS × 2^ADDR_W × DATA_W` memory with one write port and two synchronous read ports (host, sequencer). Contents are not reset.
- **Writes:** when `wr_en` is high and `wr_bank < NUM_BANKS`, write at the clock edge. Writes with an out-of-range bank are dropped.
- **Host read:** `rd_data` is updated every cycle from `{rd_bank, rd_addr}`.
  - Out-of-range bank returns 0.
  - On a same-cycle collision with a write to the same location, the port returns the old data (read-first).
- **Sequencer FSM:** states IDLE, FETCH, PRESENT.
  - **IDLE:** on `seq_start` with `seq_bank < NUM_BANKS`:
    - latch bank, `seq_last` and `seq_loop`;
    - clear idx and stop_pending;
    - go to FETCH.
  - A start with an out-of-range bank is ignored. `seq_stop` is ignored in IDLE.
  - **FETCH:** issue a sequencer read at `{bank_l, idx}`, then go to PRESENT. This read is also read-first on collision with a write.
  - **PRESENT:** `cmd_valid = 1`; `cmd_data` is the read result; `cmd_index = idx`. On `cmd_valid & cmd_ready`:
    - if `idx != last_l`: idx ← idx+1, go to FETCH;
    - else if `loop_l & ~stop_pending` and `seq_stop` is not asserted this cycle: idx ← 0, go to FETCH;
    - else: go to IDLE and pulse `seq_done`.
- **Stop:** `seq_stop` while busy sets stop_pending, which clears `loop_l`. The current pass always completes; there is no mid-pass abort. With `loop_l = 0`, stop has no visible effect.
- **Start while busy:** `seq_start` is ignored.
- **Latched parameters:** changes to `seq_bank`, `seq_last` or `seq_loop` during a run have no effect.
- **Live edits:** writes to the bank being played are allowed. A word takes effect if it is written before its FETCH cycle.
- **`seq_last = 0`:** plays one word per pass.
- **`seq_last = 2^ADDR_W-1`:** plays the whole bank. idx never wraps past `last_l`.

## Timing
- **Reset values:** FSM in IDLE; `cmd_valid` 0, `cmd_data` 0, `cmd_index` 0, `seq_busy` 0, `seq_done` 0, `rd_data` 0; stop_pending 0. Reset asserted mid-run drops `cmd_valid` immediately (asynchronously) and discards the run.
- **Host readback latency:** 1 cycle, address to `rd_data`.
- **Start latency:** with `seq_start` sampled at edge k, `seq_busy` = 1 after edge k and `cmd_valid` = 1 after edge k+1.
- **Throughput:** at most one word per 2 cycles with `cmd_ready` held high. There is one FETCH cycle with `cmd_valid` = 0 between words.
- **Handshake rules:**
  - `cmd_data` and `cmd_index` are stable while `cmd_valid & ~cmd_ready`.
  - `cmd_valid` never drops without a handshake, except on reset.
  - `cmd_ready` may be held high permanently.
- **End of run:** `seq_done` is high for exactly the cycle after the final handshake edge. In that same cycle `seq_busy` = 0, and a new `seq_start` may be sampled.

## Test plan
- **Write/readback:** write bank 3 addr 5 = 0x1234, then read bank 3 addr 5 → `rd_data` = 0x1234 one cycle later. Bank 4 addr 5 still reads its prior value. A write to bank 16 (NUM_BANKS = 16) is dropped.
- **Single pass:** bank 2 holds 0xA000+i for i = 0..3; `seq_last` = 3, `seq_loop` = 0, `cmd_ready` = 1.
  - Expect 0xA000..0xA003 with `cmd_index` 0..3 on alternating cycles.
  - `cmd_valid` first high 2 cycles after start.
  - `seq_done` pulses once; `seq_busy` falls.
- **Backpressure:** hold `cmd_ready` = 0 for 7 cycles on index 1 → `cmd_data` / `cmd_index` are stable, no index is skipped, and the order is unchanged.
- **Loop + stop:** `seq_last` = 2, `seq_loop` = 1; pulse `seq_stop` during the 2nd pass at index 0 → indices 0,1,2,0,1,2, then `seq_done`. Total handshakes = 6.
- **Boundaries:**
  - `seq_last` = 0 gives one word and then `seq_done`.
  - `seq_start` while busy is ignored.
  - Write to bank 2 addr 3 before its FETCH → the new value is played.
  - Reset during PRESENT → `cmd_valid` goes 0 asynchronously and the FSM returns to IDLE.
